// File: rtl/cc_pkg.sv
// ---------------------------------------------------------------------------
// cc_pkg
// Shared definitions for the direct-mapped read-only cache controller:
// FSM state encoding, address field widths, AXI burst/response codes and
// the IP version value served over APB.
// No ports (package).
// ---------------------------------------------------------------------------
package cc_pkg;

   // Address split: tag = addr[31:15], index = addr[14:6], word = addr[5:3]
   localparam int TAG_W      = 17;
   localparam int IDX_W      = 9;
   localparam int LINE_W     = 512;
   localparam int WORD_W     = 64;
   localparam int LINE_BEATS = 8;

   // Version register contents
   localparam logic [31:0] IP_VER = 32'h0001_2024;

   // AXI encodings used on the memory side and for responses
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [3:0] MEM_ARLEN   = 4'd7;
   localparam logic [2:0] MEM_ARSIZE  = 3'd3;

   // Controller states, one request in flight at a time
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_COMPARE,
      ST_MEM_AR,
      ST_MEM_R,
      ST_FILL,
      ST_SEND
   } ccState_e;

endpackage

// File: rtl/cache_controller_if.sv
// ---------------------------------------------------------------------------
// cc_axi_if
// AXI read-only channel bundle (AR + R). Used twice by cache_controller:
// the interconnect side as a slave and the memory side as a master.
// Signals: arid/araddr/arlen/arsize/arburst/arvalid/arready,
//          rid/rdata/rresp/rlast/rvalid/rready.
// ---------------------------------------------------------------------------
interface cc_axi_if;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   // Issuer of read requests
   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   // Responder to read requests
   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );

endinterface

// File: rtl/cc_apb_regs.sv
// ---------------------------------------------------------------------------
// cc_apb_regs
// APB register file of the cache controller: a read-only IP version
// register and, when CC_PERF_CNT_EN is defined, saturating hit/miss counters
// (0x100 hits, 0x104 misses, any write to 0x108 clears both).
// Ports: clk, rst_n, APB request (psel_i, penable_i, paddr_i, pwrite_i,
//        pwdata_i), event strobes hitInc/missInc, read data prdata_o.
// Optional feature macro: CC_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module cc_apb_regs
   import cc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic [11:0] paddr_i,
   input  logic        pwrite_i,
   input  logic [31:0] pwdata_i,
   input  logic        hitInc,
   input  logic        missInc,
   output logic [31:0] prdata_o
);

`ifdef CC_PERF_CNT_EN
   logic [31:0] hitCount;
   logic [31:0] missCount;
   logic        clearCounters;
   logic        unusedApb;

   // Write data is irrelevant: the address alone triggers the clear
   assign unusedApb     = ^pwdata_i;
   assign clearCounters = psel_i && penable_i && pwrite_i && (paddr_i == 12'h108);

   // Counters stick at all-ones rather than wrapping; clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hitCount  <= '0;
         missCount <= '0;
      end else if (clearCounters) begin
         hitCount  <= '0;
         missCount <= '0;
      end else begin
         if (hitInc && (hitCount != 32'hFFFF_FFFF))
            hitCount <= hitCount + 32'd1;
         if (missInc && (missCount != 32'hFFFF_FFFF))
            missCount <= missCount + 32'd1;
      end
   end

   // Zero-wait-state read mux; every other address returns the version
   always_comb begin
      prdata_o = IP_VER;
      case (paddr_i)
         12'h100: prdata_o = hitCount;
         12'h104: prdata_o = missCount;
         default: prdata_o = IP_VER;
      endcase
   end
`else
   logic unusedApb;

   // Without counters the block is a constant; inputs are intentionally idle
   assign unusedApb = ^{clk, rst_n, psel_i, penable_i, paddr_i, pwrite_i,
                        pwdata_i, hitInc, missInc};
   assign prdata_o  = IP_VER;
`endif

endmodule

// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
// Direct-mapped, read-only cache: 512 sets x 64-byte lines held in an
// external dual-port SRAM ({valid,tag} + 512-bit line per set). Every
// request is answered as an 8-beat, 64-bit, critical-word-first wrapping
// burst. Misses fetch the whole line from memory as one INCR burst.
// Ports: clk, rst_n; APB slave (psel_i..pslverr_o); inct (cc_axi_if.slave);
//        mem (cc_axi_if.master); SRAM read port (rden_o, raddr_o,
//        rdata_tag_i, rdata_data_i); SRAM write port (wren_o, waddr_o,
//        wdata_tag_o, wdata_data_o).
// Optional feature macro: CC_PERF_CNT_EN (APB hit/miss counters).
// ---------------------------------------------------------------------------
module cache_controller
   import cc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              psel_i,
   input  logic              penable_i,
   input  logic [11:0]       paddr_i,
   input  logic              pwrite_i,
   input  logic [31:0]       pwdata_i,
   output logic              pready_o,
   output logic [31:0]       prdata_o,
   output logic              pslverr_o,
   cc_axi_if.slave           inct,
   cc_axi_if.master          mem,
   output logic              rden_o,
   output logic [IDX_W-1:0]  raddr_o,
   input  logic [TAG_W:0]    rdata_tag_i,
   input  logic [LINE_W-1:0] rdata_data_i,
   output logic              wren_o,
   output logic [IDX_W-1:0]  waddr_o,
   output logic [TAG_W:0]    wdata_tag_o,
   output logic [LINE_W-1:0] wdata_data_o
);

   ccState_e          state;
   ccState_e          nextState;
   logic [31:0]       reqAddr;
   logic [3:0]        reqId;
   logic [LINE_W-1:0] lineBuf;
   logic              errFlag;
   logic [2:0]        memBeat;
   logic [2:0]        sendBeat;

   logic [TAG_W-1:0]  reqTag;
   logic [IDX_W-1:0]  reqIdx;
   logic [2:0]        reqWord;
   logic [2:0]        sendWord;
   logic              tagHit;
   logic              unusedSignals;

   assign reqTag   = reqAddr[31:15];
   assign reqIdx   = reqAddr[14:6];
   assign reqWord  = reqAddr[5:3];
   // 3-bit add wraps naturally, giving the critical-word-first order
   assign sendWord = reqWord + sendBeat;
   assign tagHit   = rdata_tag_i[TAG_W] && (rdata_tag_i[TAG_W-1:0] == reqTag);

   // Burst shape on the interconnect side is fixed, so these are don't-cares
   assign unusedSignals = ^{inct.arlen, inct.arsize, inct.arburst, mem.rid,
                            reqAddr[2:0]};

   // APB is zero-wait-state and never errors
   assign pready_o  = 1'b1;
   assign pslverr_o = 1'b0;

   cc_apb_regs uApbRegs (
      .clk       (clk),
      .rst_n     (rst_n),
      .psel_i    (psel_i),
      .penable_i (penable_i),
      .paddr_i   (paddr_i),
      .pwrite_i  (pwrite_i),
      .pwdata_i  (pwdata_i),
      .hitInc    ((state == ST_COMPARE) && tagHit),
      .missInc   ((state == ST_COMPARE) && !tagHit),
      .prdata_o  (prdata_o)
   );

   // State register; reset aborts whatever transaction was in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nextState;
   end

   // Datapath: request capture, line buffer loads, beat counters, error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reqAddr  <= '0;
         reqId    <= '0;
         lineBuf  <= '0;
         errFlag  <= 1'b0;
         memBeat  <= '0;
         sendBeat <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (inct.arvalid) begin
                  reqAddr <= inct.araddr;
                  reqId   <= inct.arid;
               end
            end
            ST_COMPARE: begin
               if (tagHit) lineBuf <= rdata_data_i;
            end
            ST_MEM_R: begin
               if (mem.rvalid) begin
                  lineBuf[{memBeat, 6'd0} +: WORD_W] <= mem.rdata;
                  memBeat <= mem.rlast ? 3'd0 : memBeat + 3'd1;
                  if (mem.rresp != RESP_OKAY) errFlag <= 1'b1;
               end
            end
            ST_SEND: begin
               if (inct.rready) begin
                  if (sendBeat == 3'(LINE_BEATS - 1)) begin
                     sendBeat <= '0;
                     errFlag  <= 1'b0;
                  end else begin
                     sendBeat <= sendBeat + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state and Moore-style outputs; everything idles at zero by default
   always_comb begin
      nextState     = state;
      inct.arready  = 1'b0;
      inct.rid      = '0;
      inct.rdata    = '0;
      inct.rresp    = RESP_OKAY;
      inct.rlast    = 1'b0;
      inct.rvalid   = 1'b0;
      mem.arid      = '0;
      mem.araddr    = '0;
      mem.arlen     = '0;
      mem.arsize    = '0;
      mem.arburst   = '0;
      mem.arvalid   = 1'b0;
      mem.rready    = 1'b0;
      rden_o        = 1'b0;
      raddr_o       = '0;
      wren_o        = 1'b0;
      waddr_o       = '0;
      wdata_tag_o   = '0;
      wdata_data_o  = '0;
      case (state)
         ST_IDLE: begin
            inct.arready = 1'b1;
            if (inct.arvalid) nextState = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            rden_o    = 1'b1;
            raddr_o   = reqIdx;
            nextState = ST_COMPARE;
         end
         ST_COMPARE: begin
            nextState = tagHit ? ST_SEND : ST_MEM_AR;
         end
         ST_MEM_AR: begin
            mem.arvalid = 1'b1;
            mem.araddr  = {reqAddr[31:6], 6'b0};
            mem.arlen   = MEM_ARLEN;
            mem.arsize  = MEM_ARSIZE;
            mem.arburst = BURST_INCR;
            if (mem.arready) nextState = ST_MEM_R;
         end
         ST_MEM_R: begin
            mem.rready = 1'b1;
            if (mem.rvalid && mem.rlast) nextState = ST_FILL;
         end
         ST_FILL: begin
            // A line fetched with an error is still returned but never cached
            if (!errFlag) begin
               wren_o       = 1'b1;
               waddr_o      = reqIdx;
               wdata_tag_o  = {1'b1, reqTag};
               wdata_data_o = lineBuf;
            end
            nextState = ST_SEND;
         end
         ST_SEND: begin
            inct.rvalid = 1'b1;
            inct.rdata  = lineBuf[{sendWord, 6'd0} +: WORD_W];
            inct.rid    = reqId;
            inct.rresp  = errFlag ? RESP_SLVERR : RESP_OKAY;
            inct.rlast  = (sendBeat == 3'(LINE_BEATS - 1));
            if (inct.rready && inct.rlast) nextState = ST_IDLE;
         end
         default: nextState = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_controller.sv
// ---------------------------------------------------------------------------
// tb_cache_controller
// Directed bench for cache_controller: behavioural SRAM, scripted memory
// responder and expected data computed from the address of each line.
// ---------------------------------------------------------------------------
module tb_cache_controller;
   import cc_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         psel_i, penable_i, pwrite_i;
   logic [11:0]  paddr_i;
   logic [31:0]  pwdata_i;
   logic         pready_o, pslverr_o;
   logic [31:0]  prdata_o;
   logic         rden_o, wren_o;
   logic [8:0]   raddr_o, waddr_o;
   logic [17:0]  rdata_tag_i, wdata_tag_o;
   logic [511:0] rdata_data_i, wdata_data_o;

   int compareCount = 0;
   int failCount = 0;
   int cycleCnt = 0;

   logic [17:0]  sramTag  [0:511];
   logic [511:0] sramData [0:511];

   cc_axi_if inctIf();
   cc_axi_if memIf();

   // 100 MHz clock and a free-running cycle counter for latency checks
   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Dual-port SRAM with one-cycle read latency, zero at start
   always @(posedge clk) begin
      if (rden_o) begin
         rdata_tag_i  <= sramTag[raddr_o];
         rdata_data_i <= sramData[raddr_o];
      end
      if (wren_o) begin
         sramTag[waddr_o]  <= wdata_tag_o;
         sramData[waddr_o] <= wdata_data_o;
      end
   end

   cache_controller dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .psel_i       (psel_i),
      .penable_i    (penable_i),
      .paddr_i      (paddr_i),
      .pwrite_i     (pwrite_i),
      .pwdata_i     (pwdata_i),
      .pready_o     (pready_o),
      .prdata_o     (prdata_o),
      .pslverr_o    (pslverr_o),
      .inct         (inctIf),
      .mem          (memIf),
      .rden_o       (rden_o),
      .raddr_o      (raddr_o),
      .rdata_tag_i  (rdata_tag_i),
      .rdata_data_i (rdata_data_i),
      .wren_o       (wren_o),
      .waddr_o      (waddr_o),
      .wdata_tag_o  (wdata_tag_o),
      .wdata_data_o (wdata_data_o)
   );

   // Memory content model: each beat carries its line address and beat number
   function automatic logic [63:0] memWord(input logic [31:0] lineAddr, input int k);
      return {lineAddr, 32'hA5A5_0000 + 32'(k)};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compareCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One complete inct read; errBeat/stallBeat/abortBeat = 8 means unused
   task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] id,
                                input bit expectMiss, input int errBeat,
                                input int stallBeat, input int abortBeat);
      logic [31:0] lineAddr;
      logic [2:0]  word;
      bit          err;
      int          arCycle;
      int          guard;
      int          k;
      lineAddr = {addr[31:6], 6'b0};
      word     = addr[5:3];
      err      = (errBeat < 8);
      @(negedge clk);
      inctIf.araddr  = addr;
      inctIf.arid    = id;
      inctIf.arlen   = 4'd3;
      inctIf.arsize  = 3'd2;
      inctIf.arburst = 2'b00;
      inctIf.arvalid = 1'b1;
      checkOutput("arready_idle", inctIf.arready, 1);
      @(negedge clk);
      inctIf.arvalid = 1'b0;
      arCycle = cycleCnt;
      guard = 0;
      while (!memIf.arvalid && !inctIf.rvalid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("resp_timeout", guard < 20, 1);
      checkOutput("miss_path", memIf.arvalid, expectMiss);
      if (memIf.arvalid) begin
         checkOutput("mem_araddr", memIf.araddr, lineAddr);
         checkOutput("mem_arlen", memIf.arlen, 4'd7);
         checkOutput("mem_arsize", memIf.arsize, 3'd3);
         checkOutput("mem_arburst", memIf.arburst, 2'b01);
         checkOutput("mem_arid", memIf.arid, 4'd0);
         memIf.arready = 1'b1;
         @(negedge clk);
         memIf.arready = 1'b0;
         for (k = 0; k < 8; k++) begin
            checkOutput("mem_rready", memIf.rready, 1);
            memIf.rvalid = 1'b1;
            memIf.rdata  = memWord(lineAddr, k);
            memIf.rresp  = (k == errBeat) ? 2'b10 : 2'b00;
            memIf.rlast  = (k == 7);
            memIf.rid    = 4'd0;
            if (k == abortBeat) begin
               rst_n = 1'b0;
               #1;
               checkOutput("abort_arready", inctIf.arready, 1);
               checkOutput("abort_rready", memIf.rready, 0);
               checkOutput("abort_wren", wren_o, 0);
               memIf.rvalid = 1'b0;
               memIf.rlast  = 1'b0;
               @(negedge clk);
               checkOutput("abort_no_write", wren_o, 0);
               rst_n = 1'b1;
               return;
            end
            @(negedge clk);
         end
         memIf.rvalid = 1'b0;
         memIf.rlast  = 1'b0;
         memIf.rresp  = 2'b00;
         checkOutput("fill_wren", wren_o, !err);
         if (!err) begin
            checkOutput("fill_waddr", waddr_o, lineAddr[14:6]);
            checkOutput("fill_tag", wdata_tag_o, {1'b1, lineAddr[31:15]});
            checkOutput("fill_data7", wdata_data_o[511:448], memWord(lineAddr, 7));
         end
         @(negedge clk);
      end else begin
         checkOutput("hit_latency", cycleCnt + 1 - arCycle, 3);
      end
      inctIf.rready = 1'b1;
      for (int b = 0; b < 8; b++) begin
         checkOutput("r_valid", inctIf.rvalid, 1);
         checkOutput("r_data", inctIf.rdata, memWord(lineAddr, (int'(word) + b) % 8));
         checkOutput("r_id", inctIf.rid, id);
         checkOutput("r_resp", inctIf.rresp, err ? 2'b10 : 2'b00);
         checkOutput("r_last", inctIf.rlast, b == 7);
         if (b == stallBeat) begin
            inctIf.rready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               checkOutput("stall_valid", inctIf.rvalid, 1);
               checkOutput("stall_data", inctIf.rdata,
                           memWord(lineAddr, (int'(word) + b) % 8));
               checkOutput("stall_last", inctIf.rlast, 0);
            end
            inctIf.rready = 1'b1;
         end
         @(negedge clk);
      end
      inctIf.rready = 1'b0;
      checkOutput("back_to_idle", inctIf.arready, 1);
   endtask

   // Watchdog so a stuck handshake still ends the run
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence: reset, APB, miss/hit, conflicts, stall, error, abort
   initial begin
      for (int i = 0; i < 512; i++) begin
         sramTag[i]  = '0;
         sramData[i] = '0;
      end
      rdata_tag_i  = '0;
      rdata_data_i = '0;
      psel_i = 0; penable_i = 0; pwrite_i = 0; paddr_i = '0; pwdata_i = '0;
      inctIf.arvalid = 0; inctIf.araddr = '0; inctIf.arid = '0;
      inctIf.arlen = '0; inctIf.arsize = '0; inctIf.arburst = '0;
      inctIf.rready = 0;
      memIf.arready = 0; memIf.rvalid = 0; memIf.rdata = '0;
      memIf.rresp = '0; memIf.rlast = 0; memIf.rid = '0;

      repeat (3) @(negedge clk);
      checkOutput("rst_arready", inctIf.arready, 1);
      checkOutput("rst_mem_arvalid", memIf.arvalid, 0);
      checkOutput("rst_mem_araddr", memIf.araddr, 0);
      checkOutput("rst_rvalid", inctIf.rvalid, 0);
      checkOutput("rst_rdata", inctIf.rdata, 0);
      checkOutput("rst_rden", rden_o, 0);
      checkOutput("rst_wren", wren_o, 0);
      rst_n = 1'b1;

      @(negedge clk);
      psel_i = 1; paddr_i = 12'h024; pwrite_i = 0;
      @(negedge clk);
      penable_i = 1;
      #1;
      checkOutput("apb_prdata", prdata_o, 32'h0001_2024);
      checkOutput("apb_pslverr", pslverr_o, 0);
      checkOutput("apb_pready", pready_o, 1);
      @(negedge clk);
      pwrite_i = 1; pwdata_i = 32'hDEAD_BEEF; paddr_i = 12'h3FC;
      @(negedge clk);
      pwrite_i = 0;
      #1;
      checkOutput("apb_after_write", prdata_o, 32'h0001_2024);
      psel_i = 0; penable_i = 0;

      $display("[TB] miss then hit on line 0x1240");
      applyStimulus(32'h0000_1240, 4'h5, 1, 8, 8, 8);
      applyStimulus(32'h0000_1258, 4'hA, 0, 8, 8, 8);

      $display("[TB] conflict on index 1");
      applyStimulus(32'h0000_0040, 4'h1, 1, 8, 8, 8);
      applyStimulus(32'h0000_8040, 4'h2, 1, 8, 8, 8);
      applyStimulus(32'h0000_0040, 4'h3, 1, 8, 8, 8);

      $display("[TB] rready stall mid-burst");
      applyStimulus(32'h0000_0048, 4'h4, 0, 8, 2, 8);

      $display("[TB] memory error on beat 4");
      applyStimulus(32'h0000_2000, 4'h6, 1, 4, 8, 8);
      applyStimulus(32'h0000_2000, 4'h7, 1, 8, 8, 8);
      applyStimulus(32'h0000_2010, 4'h8, 0, 8, 8, 8);

      $display("[TB] reset during memory burst");
      applyStimulus(32'h0000_3000, 4'h9, 1, 8, 8, 3);
      applyStimulus(32'h0000_3000, 4'hB, 1, 8, 8, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
